// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: default widths, FSM state encoding
// and a small helper used to decode the read phases of the FSM.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_WAIT = 2'd3
    } arb_state_t;

    function automatic logic is_read_state(input arb_state_t s);
        return (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/vram_arbiter_write_fifo.sv
// Write FIFO holding {address, data} entries from the CPU until the arbiter
// finds a free VRAM slot. Pushes while full and pops while empty are ignored.
module vram_write_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads have priority, buffered CPU writes
// are guaranteed a slot after at most MAX_READ_STREAK reads while pending.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W          = VRAM_ADDR_W,
    parameter int DATA_W          = VRAM_DATA_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_READ_STREAK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ready,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_wfull,
    output logic              vram_rden,
    output logic [ADDR_W-1:0] vram_raddr,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              vram_wren,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic              vram_wrack
);

    localparam int FIFO_W   = ADDR_W + DATA_W;
    localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STREAK_W-1:0] streak;
    logic                streak_hit;
    logic                grant_rd;
    logic                grant_wr;

    logic [ADDR_W-1:0]   raddr_p0;
    logic                vld_p2;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_W-1:0]   fifo_head;

    vram_write_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cpu_wren),
        .wdata ({cpu_waddr, cpu_wdata}),
        .pop   (grant_wr),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pending write blocks further reads once the streak is exhausted.
    assign streak_hit = !fifo_empty && (streak == STREAK_W'(MAX_READ_STREAK));

    always_comb begin
        state_next = state;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (disp_req && !streak_hit) begin
                    grant_rd   = 1'b1;
                    state_next = ST_RD_ADDR;
                end else if (!fifo_empty) begin
                    grant_wr   = 1'b1;
                    state_next = ST_WR_WAIT;
                end
            end
            ST_RD_ADDR: state_next = ST_RD_DATA;
            ST_RD_DATA: state_next = ST_IDLE;
            ST_WR_WAIT: begin
                if (vram_wrack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            streak <= '0;
            vld_p2 <= 1'b0;
        end else begin
            state  <= state_next;
            vld_p2 <= (state == ST_RD_DATA);
            if (grant_wr || fifo_empty)
                streak <= '0;
            else if (grant_rd && (streak != STREAK_W'(MAX_READ_STREAK)))
                streak <= streak + 1'b1;
        end
    end

    // Stage p0: read address captured at grant; write slot loaded on pop.
    always_ff @(posedge clk) begin
        if (grant_rd) raddr_p0 <= disp_addr;
        if (grant_wr) {waddr_q, wdata_q} <= fifo_head;
    end

    // Stage p2: VRAM output register holds the word the cycle after RD_DATA.
    assign disp_ready  = grant_rd && !reset;
    assign disp_rvalid = vld_p2;
    assign disp_rdata  = vld_p2 ? vram_rdata : '0;
    assign cpu_wfull   = fifo_full;

    assign vram_rden  = is_read_state(state);
    assign vram_raddr = vram_rden ? raddr_p0 : '0;
    assign vram_wren  = (state == ST_WR_WAIT);
    assign vram_waddr = vram_wren ? waddr_q : '0;
    assign vram_wdata = vram_wren ? wdata_q : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model with configurable write-ack delay, a
// transaction-level scoreboard run every cycle, directed corner cases and random traffic.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXS  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ready;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_wren;
    logic [AW-1:0] cpu_waddr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wfull;
    logic          vram_rden;
    logic [AW-1:0] vram_raddr;
    logic [DW-1:0] vram_rdata = '0;
    logic          vram_wren;
    logic [AW-1:0] vram_waddr;
    logic [DW-1:0] vram_wdata;
    logic          vram_wrack = 1'b0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_READ_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ready(disp_ready),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_wren(cpu_wren), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_wfull(cpu_wfull),
        .vram_rden(vram_rden), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
        .vram_wren(vram_wren), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .vram_wrack(vram_wrack)
    );

    // ---------------- VRAM model ----------------
    logic [DW-1:0] vmem [int];
    int            ack_delay = 0;
    logic          ack_hold  = 1'b0;
    int            ack_wait  = 0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 14'h0123) return 16'hBEEF;
        h = {18'd0, a} * 32'd40503 + 32'h5A5A;
        return h[15:0];
    endfunction

    function automatic logic [DW-1:0] vram_peek(input logic [AW-1:0] a);
        return vmem.exists(int'(a)) ? vmem[int'(a)] : init_val(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (vram_rden) vram_rdata <= vram_peek(vram_raddr);
            if (vram_wren && vram_wrack) vmem[int'(vram_waddr)] = vram_wdata;
            if (vram_wren && !vram_wrack && !ack_hold) begin
                if (ack_wait >= ack_delay) begin
                    vram_wrack <= 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait = ack_wait + 1;
                end
            end else begin
                vram_wrack <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic wren; logic [AW-1:0] addr; logic [DW-1:0] data; logic exp_full; } fill_vec_t;

    rd_exp_t       rq[$];
    wr_t           wq[$];
    logic [DW-1:0] ref_mem [int];
    int  n_cmp = 0, n_fail = 0, cyc = 0;
    int  mcount = 0, consec = 0, n_acks = 0, n_bursts = 0;
    logic prev_wren = 1'b0, prev_push = 1'b0, exp_pop = 1'b0;
    logic s_ready, s_rden, s_wren, s_rvalid, s_wfull;
    logic [DW-1:0] s_rdata;
    logic [AW-1:0] s_raddr, s_waddr;
    logic [DW-1:0] s_wdata;
    int  s_cyc;

    function automatic logic [DW-1:0] ref_peek(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_step();
        logic idle, popped, exp_ready, exp_rv;
        if (reset) begin
            rq.delete(); wq.delete();
            mcount = 0; consec = 0;
            prev_wren = 1'b0; prev_push = 1'b0; exp_pop = 1'b0;
        end else begin
            idle = !vram_rden && !vram_wren;
            chk("rden_wren_exclusive", 32'(vram_rden && vram_wren), 32'd0);
            if (!vram_rden) chk("raddr_zero_when_idle", 32'(vram_raddr), 32'd0);
            if (!vram_wren) begin
                chk("waddr_zero_when_idle", 32'(vram_waddr), 32'd0);
                chk("wdata_zero_when_idle", 32'(vram_wdata), 32'd0);
            end
            popped = vram_wren && !prev_wren;
            if (popped) n_bursts++;
            if (exp_pop) chk("write_grant", 32'(popped), 32'd1);
            if (popped) begin
                mcount--;
                consec = 0;
            end
            if (prev_push) mcount++;
            if (mcount == 0) consec = 0;
            chk("cpu_wfull", 32'(cpu_wfull), 32'(mcount == DEPTH));
            exp_ready = idle && disp_req && !(mcount > 0 && consec == MAXS);
            chk("disp_ready", 32'(disp_ready), 32'(exp_ready));
            exp_pop = idle && !exp_ready && (mcount > 0);
            if (disp_req && disp_ready) begin
                rq.push_back('{cyc + 3, ref_peek(disp_addr)});
                if (mcount > 0 && consec < MAXS) consec++;
            end
            exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
            chk("disp_rvalid", 32'(disp_rvalid), 32'(exp_rv));
            if (exp_rv) begin
                chk("disp_rdata", 32'(disp_rdata), 32'(rq[0].data));
                void'(rq.pop_front());
            end
            if (vram_wren && vram_wrack) begin
                n_acks++;
                if (wq.size() == 0) begin
                    chk("write_without_push", 32'd1, 32'd0);
                end else begin
                    chk("vram_waddr", 32'(vram_waddr), 32'(wq[0].addr));
                    chk("vram_wdata", 32'(vram_wdata), 32'(wq[0].data));
                    ref_mem[int'(wq[0].addr)] = wq[0].data;
                    void'(wq.pop_front());
                end
            end
            prev_push = cpu_wren && !cpu_wfull;
            if (prev_push) wq.push_back('{cpu_waddr, cpu_wdata});
            prev_wren = vram_wren;
        end
        s_ready = disp_ready; s_rden = vram_rden; s_wren = vram_wren;
        s_rvalid = disp_rvalid; s_wfull = cpu_wfull; s_rdata = disp_rdata;
        s_raddr = vram_raddr; s_waddr = vram_waddr; s_wdata = vram_wdata;
        s_cyc = cyc;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flag_ready(input string name, input int budget);
        int n;
        n = 0;
        cycle();
        while (!s_ready && n < budget) begin cycle(); n++; end
        chk(name, 32'(s_ready), 32'd1);
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (n_acks < target && n < budget) begin cycle(); n++; end
        chk(name, 32'(n_acks), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t tv[6];
        logic [DW-1:0] t2_data[3];
        int a0, b0, reads, n, rv_at, wr_at;
        bit seen;

        reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
        cpu_wren = 1'b0; cpu_waddr = '0; cpu_wdata = '0;

        // Reset state
        cycle(); cycle();
        chk("rst_disp_ready", 32'(s_ready), 32'd0);
        chk("rst_disp_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_disp_rdata", 32'(s_rdata), 32'd0);
        chk("rst_cpu_wfull", 32'(s_wfull), 32'd0);
        chk("rst_vram_rden", 32'(s_rden), 32'd0);
        chk("rst_vram_wren", 32'(s_wren), 32'd0);
        chk("rst_vram_raddr", 32'(s_raddr), 32'd0);
        chk("rst_vram_waddr", 32'(s_waddr), 32'd0);
        reset = 1'b0;
        cycle();

        // Single read with exact latency
        disp_req = 1'b1; disp_addr = 14'h0123;
        cycle();
        chk("t1_ready_T", 32'(s_ready), 32'd1);
        disp_req = 1'b0;
        cycle();
        chk("t1_rden_T1", 32'(s_rden), 32'd1);
        chk("t1_raddr_T1", 32'(s_raddr), 32'h0123);
        cycle();
        chk("t1_rden_T2", 32'(s_rden), 32'd1);
        cycle();
        chk("t1_rden_T3", 32'(s_rden), 32'd0);
        chk("t1_rvalid_T3", 32'(s_rvalid), 32'd1);
        chk("t1_rdata_T3", 32'(s_rdata), 32'hBEEF);

        // Three CPU writes, no reads
        t2_data[0] = 16'h1111; t2_data[1] = 16'h2222; t2_data[2] = 16'h3333;
        a0 = n_acks; b0 = n_bursts;
        for (int i = 0; i < 3; i++) begin
            cpu_wren = 1'b1; cpu_waddr = 14'(16 + i); cpu_wdata = t2_data[i];
            cycle();
        end
        cpu_wren = 1'b0;
        wait_acks("t2_acks", a0 + 3, 40);
        for (int i = 0; i < 3; i++) chk("t2_mem", 32'(vram_peek(14'(16 + i))), 32'(t2_data[i]));
        chk("t2_wren_per_wrack", 32'(n_bursts - b0), 32'(n_acks - a0));

        // FIFO fill while the write port is stalled
        tv[0] = '{1'b1, 14'h0021, 16'h1001, 1'b0};
        tv[1] = '{1'b1, 14'h0022, 16'h1002, 1'b0};
        tv[2] = '{1'b1, 14'h0023, 16'h1003, 1'b0};
        tv[3] = '{1'b1, 14'h0024, 16'h1004, 1'b0};
        tv[4] = '{1'b1, 14'h002F, 16'hDEAD, 1'b1};
        tv[5] = '{1'b0, 14'h0000, 16'h0000, 1'b1};
        ack_hold = 1'b1;
        cpu_wren = 1'b1; cpu_waddr = 14'h0020; cpu_wdata = 16'hAAAA;
        cycle();
        cpu_wren = 1'b0;
        n = 0;
        while (!s_wren && n < 10) begin cycle(); n++; end
        chk("t3_stalled_write", 32'(s_wren), 32'd1);
        a0 = n_acks;
        for (int i = 0; i < 6; i++) begin
            cpu_wren = tv[i].wren; cpu_waddr = tv[i].addr; cpu_wdata = tv[i].data;
            cycle();
            chk("t3_wfull_row", 32'(s_wfull), 32'(tv[i].exp_full));
        end
        cpu_wren = 1'b0;
        ack_hold = 1'b0;
        wait_acks("t3_acks", a0 + 5, 60);
        for (int i = 0; i < 4; i++) chk("t3_mem", 32'(vram_peek(tv[i].addr)), 32'(tv[i].data));
        chk("t3_dropped_push", 32'(vram_peek(14'h002F)), 32'(init_val(14'h002F)));

        // Continuous reads with one queued write: streak limit
        disp_req = 1'b1; disp_addr = 14'h0040;
        wait_flag_ready("t4_first_grant", 5);
        cpu_wren = 1'b1; cpu_waddr = 14'h0050; cpu_wdata = 16'h4444;
        cycle();
        cpu_wren = 1'b0;
        reads = 0; n = 0;
        while (!s_wren && n < 60) begin
            cycle(); n++;
            if (s_ready) reads++;
        end
        chk("t4_write_issued", 32'(s_wren), 32'd1);
        chk("t4_reads_before_write", 32'(reads), 32'(MAXS));
        wait_flag_ready("t4_reads_resume", 20);
        disp_req = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_mem", 32'(vram_peek(14'h0050)), 32'h4444);

        // Reset during RD_DATA
        disp_req = 1'b1; disp_addr = 14'h0060;
        wait_flag_ready("t5_grant", 5);
        disp_req = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        chk("t5_in_rd_data", 32'(s_rden), 32'd1);
        reset = 1'b0;
        cycle();
        chk("t5_no_rvalid", 32'(s_rvalid), 32'd0);
        chk("t5_rden_low", 32'(s_rden), 32'd0);

        // Reset during WR_WAIT with entries queued
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_wren = 1'b1; cpu_waddr = 14'(112 + i); cpu_wdata = 16'(16'h7070 + i);
            cycle();
        end
        cpu_wren = 1'b0;
        n = 0;
        while (!s_wren && n < 10) begin cycle(); n++; end
        reset = 1'b1;
        cycle();
        chk("t5_in_wr_wait", 32'(s_wren), 32'd1);
        reset = 1'b0;
        ack_hold = 1'b0;
        cycle();
        chk("t5_wren_dropped", 32'(s_wren), 32'd0);
        chk("t5_fifo_flushed", 32'(s_wfull), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_wren) seen = 1'b1;
        end
        chk("t5_no_write_after_flush", 32'(seen), 32'd0);
        for (int i = 0; i < 3; i++)
            chk("t5_mem_untouched", 32'(vram_peek(14'(112 + i))), 32'(init_val(14'(112 + i))));
        disp_req = 1'b1; disp_addr = 14'h0071;
        wait_flag_ready("t5_read_after_reset", 5);
        disp_req = 1'b0;
        n = 0;
        cycle();
        while (!s_rvalid && n < 6) begin cycle(); n++; end
        chk("t5_rvalid_after_reset", 32'(s_rvalid), 32'd1);
        chk("t5_rdata_after_reset", 32'(s_rdata), 32'(init_val(14'h0071)));

        // Simultaneous read and write on an empty FIFO
        for (int i = 0; i < 3; i++) cycle();
        disp_req = 1'b1; disp_addr = 14'h0080;
        cpu_wren = 1'b1; cpu_waddr = 14'h0081; cpu_wdata = 16'hCAFE;
        cycle();
        chk("t6_read_first", 32'(s_ready), 32'd1);
        disp_req = 1'b0; cpu_wren = 1'b0;
        rv_at = -1; wr_at = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_rvalid && rv_at < 0) rv_at = s_cyc;
            if (s_wren && wr_at < 0) wr_at = s_cyc;
        end
        chk("t6_rvalid_seen", 32'(rv_at >= 0), 32'd1);
        chk("t6_write_after_rvalid", 32'(wr_at), 32'(rv_at + 1));
        chk("t6_mem", 32'(vram_peek(14'h0081)), 32'hCAFE);

        // Random traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            if (!disp_req || s_ready) begin
                disp_req = ($urandom_range(0, 99) < 60);
                disp_addr = 14'($urandom_range(0, 63));
            end
            cpu_wren = ($urandom_range(0, 99) < 35);
            cpu_waddr = 14'($urandom_range(0, 63));
            cpu_wdata = 16'($urandom);
            if (i % 50 == 0) ack_delay = $urandom_range(0, 3);
            cycle();
        end
        disp_req = 1'b0; cpu_wren = 1'b0;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0 || mcount != 0) && n < 200) begin cycle(); n++; end
        chk("rand_drained", 32'(wq.size() + rq.size() + mcount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
